mux16_scan_ctrl: RTL
====================

# mux16_scan_ctrl

Sequencing stage directly upstream of `MUX16to1`. It accepts a 16-bit word over a valid/ready handshake, holds it on the mux data bus, and steps the 4-bit select through all 16 positions so that the mux output becomes a serial bit stream. Each bit is qualified with valid/last toward the downstream consumer, and the block honours back-pressure from that consumer.

## Interface
Parameters:
- `WIDTH`, 16: word width; fixed at 16 to match the mux.
- `SEL_W`, 4: select width, equal to log2(`WIDTH`).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_data`  in  [0:15]  word to serialise.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `aa`  out  [0:15]  latched word; drives `MUX16to1` data input.
- `ss`  out  [0:3]  select; drives `MUX16to1` select input.
- `bit_valid`  out  1  the mux output (`aa[ss]`) is a valid serial bit.
- `bit_last`  out  1  the current bit is the final beat of the word.
- `out_ready`  in  1  downstream accepts the current bit.
- `busy`  out  1  a word is being scanned.

## Operation
- Two-state FSM: `IDLE`, `SCAN`.
- `IDLE`:
  - `in_ready`=1, `bit_valid`=0.
  - On `in_valid & in_ready`: `aa`<=`in_data`, `ss`<=first index, go to `SCAN`.
- `SCAN`:
  - `bit_valid`=1 and `busy`=1.
  - A beat is accepted when `bit_valid & out_ready`.
  - On accept, `ss` advances by 1 (or by -1 in reverse mode; see Configuration).
  - Without accept, `ss` and `aa` hold. Stalls may last indefinitely.
- `bit_last` = `SCAN` and `ss` equals the final index (15 forward, 0 reverse).
- Last beat accepted:
  - If `in_valid` is high the same cycle: load the new word and stay in `SCAN` with `ss`<=first index. This is back-to-back operation with no bubble.
  - Otherwise go to `IDLE`. `aa` keeps the old word and `ss` holds its last value.
- `in_ready` = `IDLE` | (last beat accepted this cycle). This is combinational from `out_ready`.
- `aa` never changes except on a handshake load. Counter wrap from 15 to 0 never occurs inside a word.
- `in_valid` while `SCAN` and not on the last beat: ignored; the word is not consumed.
- Reset (any time, including mid-scan): the word in flight is dropped, with no partial flush.
  - Outputs after reset: `aa`=16'h0000, `ss`=4'b0000, `bit_valid`=0, `bit_last`=0, `busy`=0, `in_ready`=1.

## Timing
- Load edge N gives `bit_valid`=1 with `ss`=first index at cycle N+1.
- Minimum time per word is 16 cycles with `out_ready` held high. Sustained throughput is 1 bit/cycle.
- All outputs are registered except `in_ready`.
- The mux output settles combinationally from `aa`/`ss`, so the bit is valid in the same cycle as `bit_valid`.

## Configuration
- Macro `MUX_SCAN_REVERSE_EN`.
- Defined: adds input port `rev` (in, 1).
  - `rev` is sampled at each load and held for that word.
  - `rev`=1 scans `ss` from 15 down to 0; `bit_last` is asserted at `ss`=0.
  - `rev`=0 scans forward.
- Undefined: no `rev` port; always scans 0 to 15.

## Structure
- Package `mux_scan_pkg` holds:
  - `WIDTH`, `SEL_W` constants.
  - `typedef enum logic {IDLE, SCAN} scan_state_t`.
  - `FIRST_IDX`/`LAST_IDX` localparams.
- One sub-module, `scan_counter`: a `SEL_W`-bit up/down counter with load, enable, and a terminal-count flag. It is instantiated once for `ss`.
- The bench instantiates `mux16_scan_ctrl` with `MUX16to1` and checks the serial output `w`.

## Test plan
- Reset, then load 16'b1111000011110000 with `out_ready`=1 -> `w` sequence 1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0 on cycles N+1..N+16; `bit_last` only on the 16th beat; then `IDLE`.
- Same word, with `out_ready` low for 5 cycles at `ss`=4'b0110 -> `ss` and `w`=0 hold for 5 cycles; no beat skipped; total 21 cycles.
- Back-to-back: 16'b0000111100001111 then 16'b1010101010101010 with `in_valid` held -> second load coincides with the first word's last beat; 32 consecutive valid bits; no gap.
- `in_valid` pulsed mid-scan at `ss`=4'b1001 -> `in_ready`=0; `aa` unchanged; word not consumed.
- `rst_n` low at `ss`=4'b1100 -> all outputs at reset values immediately; the next load restarts at `ss`=0.
- `MUX_SCAN_REVERSE_EN` with `rev`=1, word 16'b1010101010101010 -> `ss` runs 15..0; `w`=0,1,0,1,...; `bit_last` at `ss`=0.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared constants and types for the 16:1 mux scan controller.
// Holds word/select widths, FSM state type and the scan end-point indices.
package mux_scan_pkg;

    localparam int WIDTH = 16;
    localparam int SEL_W = 4;

    localparam logic [SEL_W-1:0] FIRST_IDX = '0;
    localparam logic [SEL_W-1:0] LAST_IDX  = '1;

    typedef enum logic {
        IDLE,
        SCAN
    } scan_state_t;

    // Index the select starts from for a word scanned in the given direction.
    function automatic logic [SEL_W-1:0] start_idx(input logic rev);
        return rev ? LAST_IDX : FIRST_IDX;
    endfunction

endpackage

// File: rtl/mux16to1.sv
// MUX16to1: 16:1 bit multiplexer fed by the scan controller.
// Ports: aa (data word, index 0 is leftmost), ss (select), w (selected bit).
module MUX16to1 (
    input  logic [0:15] aa,
    input  logic [0:3]  ss,
    output logic        w
);

    assign w = aa[ss];

endmodule

// File: rtl/scan_counter.sv
// scan_counter: SEL_W-bit up/down counter with load, enable and terminal flag.
// Ports: clk, rst_n, load/load_val, en, down, q (count), tc (at final index).
module scan_counter
    import mux_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
    input  logic             en,
    input  logic             down,
    output logic [SEL_W-1:0] q,
    output logic             tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= down ? q - SEL_W'(1) : q + SEL_W'(1);
        end
    end

    // Terminal count is direction dependent: 0 going down, all-ones going up.
    assign tc = down ? (q == FIRST_IDX) : (q == LAST_IDX);

endmodule

// File: rtl/mux16_scan_ctrl.sv
// mux16_scan_ctrl: accepts a 16-bit word (valid/ready), holds it on the mux
// data bus and steps the select so the mux emits one bit per accepted beat.
// Ports: clk, rst_n, in_data/in_valid/in_ready (word in), aa/ss (mux drive),
// bit_valid/bit_last/out_ready (serial bit out), busy, and rev when the
// MUX_SCAN_REVERSE_EN macro is defined (scan 15 down to 0 for that word).
module mux16_scan_ctrl
    import mux_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [0:WIDTH-1] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [0:WIDTH-1] aa,
    output logic [0:SEL_W-1] ss,
    output logic             bit_valid,
    output logic             bit_last,
    input  logic             out_ready,
`ifdef MUX_SCAN_REVERSE_EN
    input  logic             rev,
`endif
    output logic             busy
);

    scan_state_t      state;
    scan_state_t      state_nxt;
    logic             accept;
    logic             last_acc;
    logic             load;
    logic             cnt_en;
    logic             tc;
    logic             rev_ld;
    logic             rev_q;
    logic [SEL_W-1:0] cnt;

`ifdef MUX_SCAN_REVERSE_EN
    assign rev_ld = rev;

    // Direction is captured with the word and held until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rev_q <= 1'b0;
        end else if (load) begin
            rev_q <= rev;
        end
    end
`else
    assign rev_ld = 1'b0;
    assign rev_q  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_acc  = 1'b0;
        in_ready  = 1'b0;
        load      = 1'b0;
        cnt_en    = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                load     = in_valid;
                if (in_valid) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                accept   = out_ready;
                last_acc = out_ready & tc;
                // Ready only on the final beat so a waiting word loads
                // without a bubble; earlier in_valid is simply ignored.
                in_ready = last_acc;
                load     = last_acc & in_valid;
                // Counter freezes on the final index when going idle.
                cnt_en   = accept & ~tc;
                if (last_acc && !in_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aa <= '0;
        end else if (load) begin
            aa <= in_data;
        end
    end

    scan_counter u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (start_idx(rev_ld)),
        .en       (cnt_en),
        .down     (rev_q),
        .q        (cnt),
        .tc       (tc)
    );

    assign ss        = cnt;
    assign bit_valid = (state == SCAN);
    assign busy      = (state == SCAN);
    assign bit_last  = (state == SCAN) & tc;

endmodule
